// File: rtl/timer_arb_pkg.sv
// -----------------------------------------------------------------------------
// timer_arb_pkg
//   Shared definitions for the shared-timer arbiter and its round-robin picker.
//   Contents:
//     NREQ_MAX    - largest requester count the arbiter is built for
//     arb_state_t - arbiter state encoding
//     wrap_inc    - modulo-n increment used for round-robin index arithmetic
// -----------------------------------------------------------------------------
package timer_arb_pkg;

  localparam int NREQ_MAX = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ARM,
    ARB_WAIT,
    ARB_RELEASE
  } arb_state_t;

  // (idx + 1) mod n, for idx already in 0..n-1.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : timer_arb_pkg

// File: rtl/timer_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker. Searches req starting at index
//   ptr and moving upward, wrapping from NREQ-1 to 0; the first set bit wins.
//   Ports:
//     req    in  NREQ  request vector
//     ptr    in  IW    index the search starts at (highest priority)
//     onehot out NREQ  one-hot winner, all-zero when no request
//     idx    out IW    winner index, 0 when no request
//     valid  out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import timer_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  int            pos;
  logic [IW-1:0] pos_idx;

  always_comb begin
    // NOTE: every output and temporary gets a default before the search so
    // no path through the loop leaves a value held, which would infer a latch.
    onehot  = '0;
    idx     = '0;
    valid   = 1'b0;
    pos     = int'(ptr);
    pos_idx = ptr;
    for (int i = 0; i < NREQ; i++) begin
      pos_idx = IW'(pos);
      if (!valid && req[pos_idx]) begin
        onehot[pos_idx] = 1'b1;
        idx             = pos_idx;
        valid           = 1'b1;
      end
      pos = wrap_inc(pos, NREQ);
    end
  end

endmodule : rr_pick

// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
//   Shares one start/ready delay timer among NREQ requesters. One requester is
//   granted at a time (round robin), the timer is started, the arbiter waits
//   for its ready flag, returns the timer to idle and pulses DONE to the owner.
//   The grant is non-preemptive: once the timer is started it always runs to
//   its end state, so a request withdrawn mid-grant still receives DONE.
//   Ports:
//     CLK        in  1     clock, rising edge
//     N_RESET    in  1     asynchronous active-low reset (shared with timer)
//     REQ        in  NREQ  level request per requester
//     GRANT      out NREQ  one-hot current owner, zero when idle
//     OWNER      out IW    index of current owner, zero when idle
//     BUSY       out 1     high in any state other than idle
//     DONE       out NREQ  one-cycle completion pulse to the owner
//     TMR_START  out 1     timer start strobe
//     TMR_RESET  out 1     timer return-to-idle strobe
//     TMR_READY  in  1     timer end-state flag
// -----------------------------------------------------------------------------
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                    CLK,
  input  logic                    N_RESET,
  input  logic [NREQ-1:0]         REQ,
  output logic [NREQ-1:0]         GRANT,
  output logic [$clog2(NREQ)-1:0] OWNER,
  output logic                    BUSY,
  output logic [NREQ-1:0]         DONE,
  output logic                    TMR_START,
  output logic                    TMR_RESET,
  input  logic                    TMR_READY
);

  localparam int IW = $clog2(NREQ);

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] grant_q;
  logic [IW-1:0]   owner_q;
  logic            busy_q;
  logic [NREQ-1:0] done_q;
  logic            start_q;
  logic            release_q;

  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (REQ),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Single-process FSM; every output except the idle stale-clear is a
  // register loaded together with the state it belongs to.
  always_ff @(posedge CLK or negedge N_RESET) begin
    // NOTE: the reset is asynchronous so a mid-grant abort clears all outputs
    // at once, without waiting for a clock edge; no DONE is produced for it.
    if (!N_RESET) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      grant_q   <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      start_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // sees the pre-edge values regardless of statement order.
      case (state)
        ARB_IDLE: begin
          // A ready flag seen in idle is left over from an earlier run; the
          // timer must be cleared (combinational strobe below) before it can
          // be started again, so no grant is issued while it is high.
          if (!TMR_READY && pick_valid) begin
            grant_q <= pick_onehot;
            owner_q <= pick_idx;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            state   <= ARB_ARM;
          end
        end

        ARB_ARM: begin
          // Ready is not looked at here: the timer has only just been strobed.
          start_q <= 1'b0;
          state   <= ARB_WAIT;
        end

        ARB_WAIT: begin
          if (TMR_READY) begin
            done_q    <= grant_q;
            release_q <= 1'b1;
            state     <= ARB_RELEASE;
          end
        end

        ARB_RELEASE: begin
          done_q    <= '0;
          release_q <= 1'b0;
          grant_q   <= '0;
          owner_q   <= '0;
          busy_q    <= 1'b0;
          ptr       <= IW'(wrap_inc(int'(owner_q), NREQ));
          state     <= ARB_IDLE;
        end

        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign GRANT     = grant_q;
  assign OWNER     = owner_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign TMR_START = start_q;
  // The stale-clear is the only output with a combinational input path; it
  // is qualified by idle, where TMR_START is always low.
  assign TMR_RESET = release_q | ((state == ARB_IDLE) && TMR_READY);

endmodule : timer_arbiter

// File: tb/tb_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timer_arbiter
//   Self-checking bench for timer_arbiter (NREQ=4) with a behavioural timer
//   whose ready flag rises 7 cycles after its start strobe (N=8). Expected
//   DONE pulses (vector and cycle) are queued when a request is driven and
//   compared by a monitor when DONE fires.
// -----------------------------------------------------------------------------
module tb_timer_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 8;

  typedef struct {
    logic [NREQ-1:0] done;
    int              at;
  } exp_t;

  logic            CLK       = 1'b0;
  logic            N_RESET   = 1'b1;
  logic [NREQ-1:0] REQ       = '0;
  logic [NREQ-1:0] GRANT;
  logic [1:0]      OWNER;
  logic            BUSY;
  logic [NREQ-1:0] DONE;
  logic            TMR_START;
  logic            TMR_RESET;
  logic            TMR_READY;

  // Behavioural shared timer.
  logic tmr_ready_q = 1'b0;
  logic tmr_run     = 1'b0;
  int   tmr_cnt     = 0;
  logic stale_force = 1'b0;

  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  logic auto_clr = 1'b1;
  exp_t sb_q[$];
  exp_t mon_e;

  timer_arbiter #(.NREQ(NREQ)) dut (
    .CLK       (CLK),
    .N_RESET   (N_RESET),
    .REQ       (REQ),
    .GRANT     (GRANT),
    .OWNER     (OWNER),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .TMR_START (TMR_START),
    .TMR_RESET (TMR_RESET),
    .TMR_READY (TMR_READY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  assign TMR_READY = tmr_ready_q | stale_force;

  always @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      tmr_ready_q <= 1'b0;
      tmr_run     <= 1'b0;
      tmr_cnt     <= 0;
    end else if (TMR_RESET) begin
      tmr_ready_q <= 1'b0;
      tmr_run     <= 1'b0;
    end else if (TMR_START) begin
      tmr_run <= 1'b1;
      tmr_cnt <= 1;
    end else if (tmr_run) begin
      tmr_cnt <= tmr_cnt + 1;
      if (tmr_cnt == N - 2) begin
        tmr_ready_q <= 1'b1;
        tmr_run     <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_done(input logic [NREQ-1:0] d, input int at);
    exp_t e;
    e.done = d;
    e.at   = at;
    sb_q.push_back(e);
  endtask

  // Advance n cycles; returns #1 after the rising edge. A requester that saw
  // DONE drops its request on that edge.
  task automatic tick(input int n = 1);
    logic [NREQ-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = DONE;
      @(posedge CLK);
      #1;
      if (auto_clr) REQ = REQ & ~d;
    end
  endtask

  task automatic rst_pulse();
    N_RESET = 1'b0;
    tick(2);
    N_RESET = 1'b1;
    tick(1);
  endtask

  // DONE monitor and strobe-exclusivity check.
  always @(negedge CLK) begin
    check("start_reset_excl", 32'(TMR_START & TMR_RESET), 0);
    if (DONE != '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(DONE), 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_vec", 32'(DONE), 32'(mon_e.done));
        check("done_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    int c0;
    int c1;
    logic [NREQ-1:0] oh;

    // Reset state.
    #1 N_RESET = 1'b0;
    tick(2);
    check("rst_grant", 32'(GRANT), 0);
    check("rst_owner", 32'(OWNER), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_start", 32'(TMR_START), 0);
    check("rst_treset", 32'(TMR_RESET), 0);
    N_RESET = 1'b1;
    tick(1);

    // Single requester.
    c0  = cyc;
    REQ = 4'b0001;
    expect_done(4'b0001, c0 + 9);
    check("s1_grant_c0", 32'(GRANT), 0);
    tick(1);
    check("s1_grant_c1", 32'(GRANT), 32'h1);
    check("s1_start_c1", 32'(TMR_START), 1);
    check("s1_owner_c1", 32'(OWNER), 0);
    check("s1_busy_c1", 32'(BUSY), 1);
    tick(1);
    check("s1_start_c2", 32'(TMR_START), 0);
    check("s1_grant_c2", 32'(GRANT), 32'h1);
    tick(8);
    check("s1_busy_c10", 32'(BUSY), 0);
    check("s1_grant_c10", 32'(GRANT), 0);

    // All request together, held: order 0,1,2,3,0.
    rst_pulse();
    auto_clr = 1'b0;
    c0  = cyc;
    REQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      expect_done(oh, c0 + 9 + 10 * k);
    end
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      tick(1);
      check("s2_grant", 32'(GRANT), 32'(oh));
      check("s2_owner", 32'(OWNER), k % 4);
      if (k == 4) REQ = 4'b0000;
      tick(9);
    end
    check("s2_busy_end", 32'(BUSY), 0);
    auto_clr = 1'b1;

    // Fairness under wrap: serve index 2, then REQ=1001 -> 3 before 0.
    rst_pulse();
    c0  = cyc;
    REQ = 4'b0100;
    expect_done(4'b0100, c0 + 9);
    tick(1);
    check("s3_grant2", 32'(GRANT), 32'h4);
    tick(9);
    c1  = cyc;
    REQ = 4'b1001;
    expect_done(4'b1000, c1 + 9);
    expect_done(4'b0001, c1 + 19);
    tick(1);
    check("s3_grant3", 32'(GRANT), 32'h8);
    check("s3_owner3", 32'(OWNER), 3);
    tick(10);
    check("s3_grant0", 32'(GRANT), 32'h1);
    check("s3_owner0", 32'(OWNER), 0);
    tick(9);
    check("s3_busy_end", 32'(BUSY), 0);

    // Stale timer in idle (pointer is 1 here).
    c0          = cyc;
    stale_force = 1'b1;
    REQ         = 4'b0010;
    #1;
    check("s4_stale_treset", 32'(TMR_RESET), 1);
    check("s4_stale_grant", 32'(GRANT), 0);
    tick(1);
    check("s4_stale_treset2", 32'(TMR_RESET), 1);
    check("s4_stale_busy", 32'(BUSY), 0);
    check("s4_stale_grant2", 32'(GRANT), 0);
    check("s4_stale_start", 32'(TMR_START), 0);
    stale_force = 1'b0;
    expect_done(4'b0010, c0 + 10);
    tick(1);
    check("s4_grant", 32'(GRANT), 32'h2);
    check("s4_start", 32'(TMR_START), 1);
    check("s4_treset", 32'(TMR_RESET), 0);
    tick(9);
    check("s4_busy_end", 32'(BUSY), 0);

    // Owner withdraws during WAIT.
    rst_pulse();
    c0  = cyc;
    REQ = 4'b1010;
    expect_done(4'b0010, c0 + 9);
    expect_done(4'b1000, c0 + 19);
    tick(1);
    check("s5_grant1", 32'(GRANT), 32'h2);
    check("s5_owner1", 32'(OWNER), 1);
    tick(3);
    REQ = 4'b1000;
    check("s5_busy_wait", 32'(BUSY), 1);
    tick(6);
    check("s5_idle_grant", 32'(GRANT), 0);
    tick(1);
    check("s5_grant3", 32'(GRANT), 32'h8);
    check("s5_owner3", 32'(OWNER), 3);
    tick(9);
    check("s5_busy_end", 32'(BUSY), 0);

    // Reset mid-WAIT: move the pointer to 2 first, then abort a grant.
    c0  = cyc;
    REQ = 4'b0010;
    expect_done(4'b0010, c0 + 9);
    tick(10);
    c1  = cyc;
    REQ = 4'b1000;
    tick(1);
    check("s6_grant3", 32'(GRANT), 32'h8);
    tick(4);
    N_RESET = 1'b0;
    REQ     = 4'b0110;
    #1;
    check("s6_rst_grant", 32'(GRANT), 0);
    check("s6_rst_owner", 32'(OWNER), 0);
    check("s6_rst_busy", 32'(BUSY), 0);
    check("s6_rst_done", 32'(DONE), 0);
    check("s6_rst_start", 32'(TMR_START), 0);
    check("s6_rst_treset", 32'(TMR_RESET), 0);
    tick(2);
    N_RESET = 1'b1;
    c0      = cyc;
    expect_done(4'b0010, c0 + 9);
    expect_done(4'b0100, c0 + 19);
    tick(1);
    check("s6_grant1", 32'(GRANT), 32'h2);
    check("s6_owner1", 32'(OWNER), 1);
    tick(10);
    check("s6_grant2", 32'(GRANT), 32'h4);
    check("s6_owner2", 32'(OWNER), 2);
    tick(9);
    check("s6_busy_end", 32'(BUSY), 0);

    tick(2);
    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_timer_arbiter

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin arbiter that shares a single start/ready delay timer among NREQ requesters. Each requester raises a level request; the arbiter grants one requester at a time, starts the timer, waits for its ready flag, and returns the timer to idle. It then pulses DONE to the granted requester. It sits between the delay consumers and the one shared timer instance; it owns the timer's START and RESET inputs exclusively.

## Interface
- NREQ, 4, number of requesters; 2..16.
- CLK  in  1  clock, rising edge.
- N_RESET  in  1  reset, asynchronous, active-low; also wired to the shared timer.
- REQ  in  NREQ  level request per requester; held high until DONE for that requester is seen.
- GRANT  out  NREQ  one-hot current owner; all-zero when idle.
- OWNER  out  $clog2(NREQ)  index of current owner; 0 when idle.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  NREQ  one-hot, one-cycle completion pulse to the owner.
- TMR_START  out  1  timer start strobe.
- TMR_RESET  out  1  timer return-to-idle strobe.
- TMR_READY  in  1  timer end-state flag.

## Operation
- State machine (Moore outputs): IDLE, ARM, WAIT, RELEASE.
- IDLE:
  - if TMR_READY=1 (stale timer), drive TMR_RESET=1, issue no grant, stay in IDLE;
  - else if REQ≠0, latch the winner from the round-robin picker into GRANT/OWNER and go to ARM;
  - else stay in IDLE.
- ARM: TMR_START=1 for exactly one cycle; go to WAIT.
- WAIT: hold GRANT; on TMR_READY=1 go to RELEASE; otherwise stay.
- RELEASE:
  - TMR_RESET=1, DONE[OWNER]=1;
  - pointer ← (OWNER+1) mod NREQ;
  - next cycle clear GRANT/OWNER and go to IDLE.
- Round robin: search REQ from the pointer index upward, wrapping at NREQ-1→0; the first set bit wins. Pointer reset value 0.
- Grant is non-preemptive. A REQ from the owner that drops during ARM/WAIT does not abort. The timer cannot be aborted before its end state, so the grant runs to completion and DONE still pulses.
- TMR_READY is ignored in ARM.
- TMR_START and TMR_RESET are never high in the same cycle.
- Reset values: state IDLE, GRANT=0, OWNER=0, BUSY=0, DONE=0, TMR_START=0, TMR_RESET=0, pointer=0.
- N_RESET asserted mid-grant: immediate return to IDLE and all outputs to reset values; no DONE is issued for the aborted grant. The timer is reset by the same signal.

## Timing
- All state, pointer, GRANT and OWNER are registered. Outputs are decoded from registered state only; no combinational path from REQ or TMR_READY to any output, except TMR_RESET in IDLE (stale-clear).
- For a timer whose ready flag rises N-1 cycles after its start strobe:
  - cycle 0: REQ seen in IDLE;
  - cycle 1: ARM;
  - cycle N: TMR_READY;
  - cycle N+1: RELEASE with DONE;
  - cycle N+2: IDLE.
- REQ-to-DONE latency is N+1 cycles. Back-to-back grant period is N+2 cycles.
- Requester protocol: a requester clears REQ on the edge at which it samples DONE=1, so REQ is low in the following IDLE cycle. A REQ still high there is treated as a new request.
- Simultaneous new REQs during a grant are only sampled in IDLE.

## Structure
- Package timer_arb_pkg contains:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ARM, ARB_WAIT, ARB_RELEASE};
  - localparam NREQ_MAX=16.
- Sub-module rr_pick: purely combinational. Inputs are REQ and the pointer; outputs are the one-hot winner, the winner index, and a valid flag. Reused by other arbiters in the design.
- timer_arbiter holds the state register, the pointer register, the GRANT/OWNER registers, and output decode. The shared timer is instantiated alongside it in the parent, not inside it.

## Test plan
All scenarios use NREQ=4 and a timer with N=8.
- Single requester: REQ=0001 at cycle 0 -> GRANT=0001 from cycle 1, TMR_START at cycle 1, DONE=0001 at cycle 9, BUSY low and GRANT=0000 at cycle 10.
- All request together: REQ=1111 held -> grant order 0,1,2,3,0. Each grant lasts 10 cycles; exactly one DONE bit per grant.
- Fairness under wrap:
  - pointer=3 after serving index 2, REQ=1001 -> index 3 is granted before index 0;
  - then index 0 is granted next.
- Stale timer: force TMR_READY=1 in IDLE with REQ=0010 -> TMR_RESET high, no GRANT until TMR_READY falls; grant issued on the next IDLE cycle.
- Owner withdraws: REQ[1] dropped during WAIT -> grant continues, DONE[1] still pulses at cycle N+1, then the next requester is served.
- Reset mid-WAIT: assert N_RESET at cycle 5 of a grant -> all outputs zero immediately, no DONE. After release, a pending REQ is granted from pointer 0.
